xfer_status_gen: RTL



---
 rtl/xfer_status_gen.sv | 81 ++++++++
 1 files changed

// File: rtl/xfer_status_gen.sv
// xfer_status_gen: request/ack transfer sequencer with bounded wait,
// driving registered Wait/Valid/Error/Timeout/Clear status levels.
module xfer_status_gen #(
    parameter int TIMEOUT = 4,
    parameter int CW      = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req,
    input  logic          Ack,
    input  logic          Nak,
    input  logic          Abort,
    input  logic          ErrAck,
    output logic          Wait,
    output logic          Valid,
    output logic          Error,
    output logic          Timeout,
    output logic          Clear,
    output logic [CW-1:0] WaitCnt
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_FAIL, S_CLR} state_t;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cause_q, cause_d;
    logic          wait_q, valid_q, error_q, timeout_q, clear_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: if (Req) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: if (Abort) state_d = S_CLR;
                else if (Nak) begin
                    state_d = S_FAIL;
                    cause_d = 1'b0;
                end else if (Ack) state_d = S_DONE;
                else if (cnt_q == LAST) begin
                    state_d = S_FAIL;
                    cause_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            S_DONE: state_d = S_IDLE;
            S_FAIL: if (Abort || ErrAck) begin
                state_d = S_CLR;
                cause_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // Status outputs are decoded from the next state so they register with it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cause_q   <= 1'b0;
            wait_q    <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            wait_q    <= state_d == S_WAIT;
            valid_q   <= state_d == S_DONE;
            error_q   <= state_d == S_FAIL;
            timeout_q <= state_d == S_FAIL && cause_d;
            clear_q   <= state_d == S_CLR;
        end
    end
    assign Wait    = wait_q;
    assign Valid   = valid_q;
    assign Error   = error_q;
    assign Timeout = timeout_q;
    assign Clear   = clear_q;
    assign WaitCnt = cnt_q;
endmodule
